// File: rtl/header_relay.sv
// header_relay: strips a fixed-length header from each request packet arriving
// from the network and stores it. The header is re-inserted in front of the
// matching application response on its way back to the network. Headers pair
// with responses in strict FIFO order.
//
// Ports
//   apclk, apreset          : single clock, synchronous active-high reset
//   fromNet_axis_*          : request stream in (header + payload)
//   toApp_axis_*            : request payload out (header stripped)
//   fromApp_axis_*          : response payload in
//   toNet_axis_*            : response out (stored header + payload)
//   hdr_count               : number of occupied header slots
//   drop_cnt                : saturating count of dropped request packets
module header_relay #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned KEEP_W    = DATA_W / 8,
  parameter int unsigned USER_W    = 64,
  parameter int unsigned HDR_BEATS = 6,
  parameter int unsigned HDR_DEPTH = 4
) (
  input  logic                          apclk,
  input  logic                          apreset,
  input  logic [DATA_W-1:0]             fromNet_axis_tdata,
  input  logic [KEEP_W-1:0]             fromNet_axis_tkeep,
  input  logic [USER_W-1:0]             fromNet_axis_tuser,
  input  logic                          fromNet_axis_tlast,
  input  logic                          fromNet_axis_tvalid,
  output logic                          fromNet_axis_tready,
  output logic [DATA_W-1:0]             toApp_axis_tdata,
  output logic [KEEP_W-1:0]             toApp_axis_tkeep,
  output logic [USER_W-1:0]             toApp_axis_tuser,
  output logic                          toApp_axis_tlast,
  output logic                          toApp_axis_tvalid,
  input  logic                          toApp_axis_tready,
  input  logic [DATA_W-1:0]             fromApp_axis_tdata,
  input  logic [KEEP_W-1:0]             fromApp_axis_tkeep,
  input  logic [USER_W-1:0]             fromApp_axis_tuser,
  input  logic                          fromApp_axis_tlast,
  input  logic                          fromApp_axis_tvalid,
  output logic                          fromApp_axis_tready,
  output logic [DATA_W-1:0]             toNet_axis_tdata,
  output logic [KEEP_W-1:0]             toNet_axis_tkeep,
  output logic [USER_W-1:0]             toNet_axis_tuser,
  output logic                          toNet_axis_tlast,
  output logic                          toNet_axis_tvalid,
  input  logic                          toNet_axis_tready,
  output logic [$clog2(HDR_DEPTH):0]    hdr_count,
  output logic [31:0]                   drop_cnt
);

  localparam int unsigned PTR_W  = $clog2(HDR_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int unsigned MEM_N  = HDR_DEPTH * HDR_BEATS;
  localparam int unsigned ADDR_W = $clog2(MEM_N);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(HDR_BEATS - 1);

  typedef enum logic [1:0] {NetHdr, NetPay, NetDrop} net_st_e;
  typedef enum logic [1:0] {AppIdle, AppHdr, AppPay} app_st_e;

  net_st_e             net_st_q, net_st_d;
  app_st_e             app_st_q, app_st_d;
  logic [IDX_W-1:0]    idx_q, idx_d, ridx_q, ridx_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    hdr_count_q, hdr_count_d;
  logic [31:0]         drop_cnt_q, drop_cnt_d;
  logic                rst_q;
  logic [DATA_W-1:0]   hdr_mem_q [MEM_N];

  logic blk, hdr_full;
  logic net_rdy, net_fwd, net_hs, hdr_we, commit, drop_inc;
  logic app_rdy, app_vld, app_hs, free;
  logic [ADDR_W-1:0] waddr, raddr;

  // Handshakes are suppressed while in reset and for one cycle after it.
  assign blk      = apreset | rst_q;
  assign hdr_full = (hdr_count_q == CNT_W'(HDR_DEPTH));
  assign waddr    = ADDR_W'(wptr_q) * ADDR_W'(HDR_BEATS) + ADDR_W'(idx_q);
  assign raddr    = ADDR_W'(rptr_q) * ADDR_W'(HDR_BEATS) + ADDR_W'(ridx_q);

  assign hdr_count = hdr_count_q;
  assign drop_cnt  = drop_cnt_q;

  assign toApp_axis_tdata = fromNet_axis_tdata;
  assign toApp_axis_tkeep = fromNet_axis_tkeep;
  assign toApp_axis_tuser = fromNet_axis_tuser;
  assign toApp_axis_tlast = fromNet_axis_tlast;

  // Net path: capture header, forward payload, or discard.
  always_comb begin
    net_st_d = net_st_q;
    idx_d    = idx_q;
    net_rdy  = 1'b0;
    net_fwd  = 1'b0;
    hdr_we   = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    unique case (net_st_q)
      NetHdr, NetDrop: net_rdy = 1'b1;
      NetPay: begin
        net_rdy = toApp_axis_tready;
        net_fwd = fromNet_axis_tvalid;
      end
      default: ;
    endcase
    fromNet_axis_tready = net_rdy & ~blk;
    toApp_axis_tvalid   = net_fwd & ~blk;
    net_hs              = fromNet_axis_tvalid & net_rdy & ~blk;

    if (net_hs) begin
      unique case (net_st_q)
        NetHdr: begin
          if (idx_q == '0 && hdr_full) begin
            // No free slot at packet start: swallow the whole packet.
            if (fromNet_axis_tlast) drop_inc = 1'b1;
            else                    net_st_d = NetDrop;
          end else begin
            hdr_we = 1'b1;
            if (fromNet_axis_tlast) begin
              // Runt: packet ended inside the header.
              idx_d    = '0;
              drop_inc = 1'b1;
            end else if (idx_q == LastIdx) begin
              idx_d    = '0;
              commit   = 1'b1;
              net_st_d = NetPay;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        NetPay:  if (fromNet_axis_tlast) net_st_d = NetHdr;
        NetDrop: if (fromNet_axis_tlast) begin
          drop_inc = 1'b1;
          net_st_d = NetHdr;
        end
        default: net_st_d = NetHdr;
      endcase
    end
  end

  // App path: replay stored header, then forward the response payload.
  always_comb begin
    app_st_d         = app_st_q;
    ridx_d           = ridx_q;
    app_rdy          = 1'b0;
    app_vld          = 1'b0;
    free             = 1'b0;
    toNet_axis_tdata = hdr_mem_q[raddr];
    toNet_axis_tkeep = '1;
    toNet_axis_tuser = '0;
    toNet_axis_tlast = 1'b0;
    unique case (app_st_q)
      AppIdle: if (fromApp_axis_tvalid && hdr_count_q != '0) app_st_d = AppHdr;
      AppHdr:  app_vld = 1'b1;
      AppPay: begin
        app_vld          = fromApp_axis_tvalid;
        app_rdy          = toNet_axis_tready;
        toNet_axis_tdata = fromApp_axis_tdata;
        toNet_axis_tkeep = fromApp_axis_tkeep;
        toNet_axis_tuser = fromApp_axis_tuser;
        toNet_axis_tlast = fromApp_axis_tlast;
      end
      default: app_st_d = AppIdle;
    endcase
    toNet_axis_tvalid   = app_vld & ~blk;
    fromApp_axis_tready = app_rdy & ~blk;
    app_hs              = app_vld & toNet_axis_tready & ~blk;

    if (app_hs && app_st_q == AppHdr) begin
      if (ridx_q == LastIdx) begin
        ridx_d   = '0;
        app_st_d = AppPay;
      end else begin
        ridx_d = ridx_q + 1'b1;
      end
    end
    if (app_hs && app_st_q == AppPay && fromApp_axis_tlast) begin
      free     = 1'b1;
      app_st_d = AppIdle;
    end
  end

  // Slot bookkeeping shared by both paths.
  always_comb begin
    wptr_d      = commit ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = free ? rptr_q + 1'b1 : rptr_q;
    hdr_count_d = hdr_count_q;
    if (commit && !free)      hdr_count_d = hdr_count_q + 1'b1;
    else if (free && !commit) hdr_count_d = hdr_count_q - 1'b1;
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge apclk) begin
    rst_q <= apreset;
    if (apreset) begin
      net_st_q    <= NetHdr;
      app_st_q    <= AppIdle;
      idx_q       <= '0;
      ridx_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      hdr_count_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      net_st_q    <= net_st_d;
      app_st_q    <= app_st_d;
      idx_q       <= idx_d;
      ridx_q      <= ridx_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      hdr_count_q <= hdr_count_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge apclk) begin
    if (hdr_we) hdr_mem_q[waddr] <= fromNet_axis_tdata;
  end

endmodule

// File: tb/tb_header_relay.sv
// Self-checking bench for header_relay: directed cases plus randomized
// packets with backpressure, compared against a queue-based packet model.
module tb_header_relay;
  localparam int DW = 64, KW = 8, UW = 64, HB = 6, HD = 4;
  localparam int TMO = 4000;
  localparam int NPKT = 100;

  logic apclk = 1'b0;
  logic apreset;
  always #5 apclk = ~apclk;

  logic [DW-1:0] fromNet_axis_tdata, toApp_axis_tdata, fromApp_axis_tdata, toNet_axis_tdata;
  logic [KW-1:0] fromNet_axis_tkeep, toApp_axis_tkeep, fromApp_axis_tkeep, toNet_axis_tkeep;
  logic [UW-1:0] fromNet_axis_tuser, toApp_axis_tuser, fromApp_axis_tuser, toNet_axis_tuser;
  logic fromNet_axis_tlast, fromNet_axis_tvalid, fromNet_axis_tready;
  logic toApp_axis_tlast, toApp_axis_tvalid, toApp_axis_tready;
  logic fromApp_axis_tlast, fromApp_axis_tvalid, fromApp_axis_tready;
  logic toNet_axis_tlast, toNet_axis_tvalid, toNet_axis_tready;
  logic [2:0]  hdr_count;
  logic [31:0] drop_cnt;

  header_relay #(
    .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .HDR_BEATS(HB), .HDR_DEPTH(HD)
  ) dut (
    .apclk(apclk), .apreset(apreset),
    .fromNet_axis_tdata(fromNet_axis_tdata), .fromNet_axis_tkeep(fromNet_axis_tkeep),
    .fromNet_axis_tuser(fromNet_axis_tuser), .fromNet_axis_tlast(fromNet_axis_tlast),
    .fromNet_axis_tvalid(fromNet_axis_tvalid), .fromNet_axis_tready(fromNet_axis_tready),
    .toApp_axis_tdata(toApp_axis_tdata), .toApp_axis_tkeep(toApp_axis_tkeep),
    .toApp_axis_tuser(toApp_axis_tuser), .toApp_axis_tlast(toApp_axis_tlast),
    .toApp_axis_tvalid(toApp_axis_tvalid), .toApp_axis_tready(toApp_axis_tready),
    .fromApp_axis_tdata(fromApp_axis_tdata), .fromApp_axis_tkeep(fromApp_axis_tkeep),
    .fromApp_axis_tuser(fromApp_axis_tuser), .fromApp_axis_tlast(fromApp_axis_tlast),
    .fromApp_axis_tvalid(fromApp_axis_tvalid), .fromApp_axis_tready(fromApp_axis_tready),
    .toNet_axis_tdata(toNet_axis_tdata), .toNet_axis_tkeep(toNet_axis_tkeep),
    .toNet_axis_tuser(toNet_axis_tuser), .toNet_axis_tlast(toNet_axis_tlast),
    .toNet_axis_tvalid(toNet_axis_tvalid), .toNet_axis_tready(toNet_axis_tready),
    .hdr_count(hdr_count), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic [DW-1:0] d;
  } beat_t;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packet storage and reference model state.
  beat_t         req_b[$], rsp_b[$];
  int            req_s[$], req_n[$], rsp_s[$], rsp_n[$];
  beat_t         exp_app[$], exp_net[$];
  logic [DW-1:0] hdr_q[$];   // HB entries per stored header
  int            exp_drop = 0;
  int            net_done = 0;
  bit            mon_net = 1'b1;
  bit            bp_en = 1'b0;
  int unsigned   cyc = 0;

  function automatic int add_req(input int n, input bit seq);
    beat_t b;
    req_s.push_back(req_b.size());
    req_n.push_back(n);
    for (int i = 0; i < n; i++) begin
      b.d = seq ? DW'(i) : {$urandom, $urandom};
      b.k = seq ? '1 : KW'($urandom);
      b.u = seq ? '0 : {$urandom, $urandom};
      b.l = (i == n - 1);
      req_b.push_back(b);
    end
    return req_n.size() - 1;
  endfunction

  function automatic int add_rsp(input int n, input bit seq);
    beat_t b;
    rsp_s.push_back(rsp_b.size());
    rsp_n.push_back(n);
    for (int i = 0; i < n; i++) begin
      b.d = seq ? DW'(64'hA0 + i) : {$urandom, $urandom};
      b.k = seq ? '1 : KW'($urandom);
      b.u = seq ? '0 : {$urandom, $urandom};
      b.l = (i == n - 1);
      rsp_b.push_back(b);
    end
    return rsp_n.size() - 1;
  endfunction

  // A request either loses its header (committed) or is dropped whole.
  function automatic void model_req(input int id, input bit full);
    int s = req_s[id];
    int n = req_n[id];
    if (n <= HB || full) begin
      exp_drop++;
    end else begin
      for (int i = 0; i < HB; i++) hdr_q.push_back(req_b[s + i].d);
      for (int i = HB; i < n; i++) exp_app.push_back(req_b[s + i]);
    end
  endfunction

  // A response is prefixed by the oldest stored header.
  function automatic void model_rsp(input int id);
    beat_t b;
    for (int i = 0; i < HB; i++) begin
      b = {1'b0, {KW{1'b1}}, {UW{1'b0}}, hdr_q.pop_front()};
      exp_net.push_back(b);
    end
    for (int i = 0; i < rsp_n[id]; i++) exp_net.push_back(rsp_b[rsp_s[id] + i]);
  endfunction

  task automatic send_req(input int id, input int gap);
    beat_t b;
    logic  hs;
    for (int i = 0; i < req_n[id]; i++) begin
      repeat ($urandom_range(0, gap)) begin
        fromNet_axis_tvalid = 1'b0;
        @(posedge apclk); #1;
      end
      b = req_b[req_s[id] + i];
      {fromNet_axis_tlast, fromNet_axis_tkeep, fromNet_axis_tuser, fromNet_axis_tdata} = b;
      fromNet_axis_tvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < TMO && !hs; c++) begin
        @(negedge apclk);
        hs = fromNet_axis_tready;
        @(posedge apclk); #1;
      end
      if (!hs) check("net_in_timeout", 160'(hs), 160'(1));
    end
    fromNet_axis_tvalid = 1'b0;
  endtask

  task automatic send_rsp(input int id, input int gap);
    beat_t b;
    logic  hs;
    for (int i = 0; i < rsp_n[id]; i++) begin
      repeat ($urandom_range(0, gap)) begin
        fromApp_axis_tvalid = 1'b0;
        @(posedge apclk); #1;
      end
      b = rsp_b[rsp_s[id] + i];
      {fromApp_axis_tlast, fromApp_axis_tkeep, fromApp_axis_tuser, fromApp_axis_tdata} = b;
      fromApp_axis_tvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < TMO && !hs; c++) begin
        @(negedge apclk);
        hs = fromApp_axis_tready;
        @(posedge apclk); #1;
      end
      if (!hs) check("app_in_timeout", 160'(hs), 160'(1));
    end
    fromApp_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < TMO && (exp_app.size() != 0 || exp_net.size() != 0); c++) begin
      @(posedge apclk); #1;
    end
    repeat (2) @(posedge apclk);
    #1;
    check("drain_app", 160'(exp_app.size()), 160'(0));
    check("drain_net", 160'(exp_net.size()), 160'(0));
  endtask

  task automatic do_reset();
    apreset = 1'b1;
    fromNet_axis_tvalid = 1'b0;
    fromApp_axis_tvalid = 1'b0;
    repeat (2) @(posedge apclk);
    #1;
    apreset = 1'b0;
    hdr_q.delete();
    exp_app.delete();
    exp_net.delete();
    exp_drop = 0;
  endtask

  // Output monitors, sampled mid-cycle.
  always @(negedge apclk) begin
    beat_t g, e;
    if (toApp_axis_tvalid && toApp_axis_tready) begin
      g = {toApp_axis_tlast, toApp_axis_tkeep, toApp_axis_tuser, toApp_axis_tdata};
      if (exp_app.size() == 0) check("app_unexpected", 160'(exp_app.size()), 160'(1));
      else begin
        e = exp_app.pop_front();
        check("app_beat", 160'(g), 160'(e));
      end
    end
    if (toNet_axis_tvalid && toNet_axis_tready) begin
      if (toNet_axis_tlast) net_done++;
      if (mon_net) begin
        g = {toNet_axis_tlast, toNet_axis_tkeep, toNet_axis_tuser, toNet_axis_tdata};
        if (exp_net.size() == 0) check("net_unexpected", 160'(exp_net.size()), 160'(1));
        else begin
          e = exp_net.pop_front();
          check("net_beat", 160'(g), 160'(e));
        end
      end
    end
  end

  // Sink-side ready generators: periodic low windows when enabled.
  initial begin
    toApp_axis_tready = 1'b1;
    toNet_axis_tready = 1'b1;
    forever begin
      @(posedge apclk); #1;
      cyc++;
      toApp_axis_tready = !bp_en || (cyc % 49) >= 9;
      toNet_axis_tready = !bp_en || (cyc % 60) >= 10;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  int rq_ids[NPKT], rs_ids[NPKT];
  int id, rid, done0, cw;
  bit found;

  initial begin
    apreset = 1'b1;
    {fromNet_axis_tdata, fromNet_axis_tkeep, fromNet_axis_tuser} = '0;
    {fromApp_axis_tdata, fromApp_axis_tkeep, fromApp_axis_tuser} = '0;
    fromNet_axis_tlast = 1'b0; fromNet_axis_tvalid = 1'b0;
    fromApp_axis_tlast = 1'b0; fromApp_axis_tvalid = 1'b0;

    // Reset state and the blocked cycle after reset.
    @(posedge apclk); #1;
    @(negedge apclk);
    check("rst_hdr_count", 160'(hdr_count), 160'(0));
    check("rst_drop_cnt", 160'(drop_cnt), 160'(0));
    check("rst_toapp_valid", 160'(toApp_axis_tvalid), 160'(0));
    check("rst_tonet_valid", 160'(toNet_axis_tvalid), 160'(0));
    check("rst_net_ready", 160'(fromNet_axis_tready), 160'(0));
    check("rst_app_ready", 160'(fromApp_axis_tready), 160'(0));
    @(posedge apclk); #1;
    apreset = 1'b0;
    check("post_rst_net_ready", 160'(fromNet_axis_tready), 160'(0));
    @(posedge apclk); #1;
    check("idle_net_ready", 160'(fromNet_axis_tready), 160'(1));

    // 10-beat request: payload 6..9 forwarded, one header stored.
    id = add_req(10, 1'b1);
    model_req(id, 1'b0);
    send_req(id, 0);
    drain();
    check("t1_hdr_count", 160'(hdr_count), 160'(hdr_q.size() / HB));

    // 3-beat response: header 0..5 then A0..A2.
    rid = add_rsp(3, 1'b1);
    model_rsp(rid);
    send_rsp(rid, 0);
    drain();
    check("t2_hdr_count", 160'(hdr_count), 160'(0));

    // Five requests into a four-slot store: fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      id = add_req(8 + i, 1'b0);
      model_req(id, (hdr_q.size() / HB) >= HD);
      send_req(id, 1);
    end
    drain();
    check("t3_drop_cnt", 160'(drop_cnt), 160'(exp_drop));
    check("t3_hdr_count", 160'(hdr_count), 160'(hdr_q.size() / HB));
    for (int i = 0; i < HD; i++) begin
      rid = add_rsp(1 + i, 1'b0);
      model_rsp(rid);
      send_rsp(rid, 1);
    end
    drain();
    check("t3_hdr_empty", 160'(hdr_count), 160'(0));

    // Runts: 4 beats, then exactly HB beats; app side must stay stalled.
    do_reset();
    id = add_req(4, 1'b1);
    model_req(id, 1'b0);
    send_req(id, 0);
    drain();
    check("t4_drop_cnt", 160'(drop_cnt), 160'(exp_drop));
    check("t4_hdr_count", 160'(hdr_count), 160'(0));
    fromApp_axis_tvalid = 1'b1;
    fromApp_axis_tdata = 64'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge apclk);
      check("t4_app_ready", 160'(fromApp_axis_tready), 160'(0));
      check("t4_net_valid", 160'(toNet_axis_tvalid), 160'(0));
    end
    @(posedge apclk); #1;
    fromApp_axis_tvalid = 1'b0;
    id = add_req(HB, 1'b0);
    model_req(id, 1'b0);
    send_req(id, 0);
    drain();
    check("t4_runt_exact_drop", 160'(drop_cnt), 160'(exp_drop));
    check("t4_runt_exact_hdr", 160'(hdr_count), 160'(0));

    // Random packets with periodic backpressure on both sinks.
    bp_en = 1'b1;
    for (int i = 0; i < NPKT; i++) begin
      rq_ids[i] = add_req(HB + 1 + $urandom_range(0, 5), 1'b0);
      rs_ids[i] = add_rsp($urandom_range(1, 5), 1'b0);
      model_req(rq_ids[i], 1'b0);
      model_rsp(rs_ids[i]);
    end
    done0 = net_done;
    fork
      begin
        for (int i = 0; i < NPKT; i++) begin
          // Keep fewer than HD headers outstanding so nothing is dropped.
          cw = 0;
          while (net_done - done0 + HD <= i && cw < TMO) begin
            @(posedge apclk); #1;
            cw++;
          end
          if (cw >= TMO) check("outstanding_timeout", 160'(cw), 160'(0));
          send_req(rq_ids[i], 2);
        end
      end
      begin
        for (int j = 0; j < NPKT; j++) send_rsp(rs_ids[j], 2);
      end
    join
    drain();
    bp_en = 1'b0;
    check("t5_drop_cnt", 160'(drop_cnt), 160'(exp_drop));
    check("t5_hdr_count", 160'(hdr_count), 160'(0));
    check("t5_resp_count", 160'(net_done - done0), 160'(NPKT));

    // Reset while toNet presents header beat 3.
    id = add_req(10, 1'b1);
    model_req(id, 1'b0);
    send_req(id, 0);
    drain();
    mon_net = 1'b0;
    fromApp_axis_tdata = 64'h77;
    fromApp_axis_tlast = 1'b1;
    fromApp_axis_tvalid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < TMO && !found; c++) begin
      @(negedge apclk);
      found = toNet_axis_tvalid && toNet_axis_tdata == 64'd3;
    end
    check("t6_hdr_beat3_seen", 160'(found), 160'(1));
    apreset = 1'b1;
    #1;
    check("t6_rst_net_valid", 160'(toNet_axis_tvalid), 160'(0));
    @(posedge apclk); #1;
    apreset = 1'b0;
    fromApp_axis_tvalid = 1'b0;
    check("t6_after_net_valid", 160'(toNet_axis_tvalid), 160'(0));
    check("t6_after_net_ready", 160'(fromNet_axis_tready), 160'(0));
    check("t6_hdr_count", 160'(hdr_count), 160'(0));
    check("t6_drop_cnt", 160'(drop_cnt), 160'(0));
    hdr_q.delete();
    exp_net.delete();
    exp_drop = 0;
    @(posedge apclk); #1;
    mon_net = 1'b1;
    id = add_req(9, 1'b0);
    rid = add_rsp(2, 1'b0);
    model_req(id, 1'b0);
    model_rsp(rid);
    send_req(id, 0);
    send_rsp(rid, 0);
    drain();
    check("t6_final_hdr_count", 160'(hdr_count), 160'(0));
    check("t6_final_drop_cnt", 160'(drop_cnt), 160'(exp_drop));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/header_relay.md
HEADER_RELAY -- requirements
Module: header_relay

Interface
REQ-001 Parameters: DATA_W, default 64, beat width in bits (multiple of 8); KEEP_W, default DATA_W/8, tkeep width; USER_W, default 64, tuser width; HDR_BEATS, default 6, header length in beats (1..16); HDR_DEPTH, default 4, header store slots (power of 2, >=2).
REQ-002 apclk  in  1  single clock; all logic on rising edge.
REQ-003 apreset  in  1  synchronous, active-high reset.
REQ-004 fromNet_axis_{tdata,tkeep,tuser,tlast,tvalid}  in  DATA_W/KEEP_W/USER_W/1/1  request stream from network; fromNet_axis_tready  out  1.
REQ-005 toApp_axis_{tdata,tkeep,tuser,tlast,tvalid}  out  DATA_W/KEEP_W/USER_W/1/1  header-stripped request payload; toApp_axis_tready  in  1.
REQ-006 fromApp_axis_{tdata,tkeep,tuser,tlast,tvalid}  in  DATA_W/KEEP_W/USER_W/1/1  response payload from application; fromApp_axis_tready  out  1.
REQ-007 toNet_axis_{tdata,tkeep,tuser,tlast,tvalid}  out  DATA_W/KEEP_W/USER_W/1/1  response with header re-inserted; toNet_axis_tready  in  1.
REQ-008 hdr_count  out  clog2(HDR_DEPTH)+1  occupied header slots; drop_cnt  out  32  dropped request packets.

Function
REQ-009 Beat transfers on tvalid&tready only; tvalid, once asserted, holds with stable payload until accepted.
REQ-010 Net path FSM states N_HDR, N_PAY, N_DROP; reset state N_HDR, beat index 0.
REQ-011 N_HDR, hdr_count<HDR_DEPTH: fromNet_axis_tready=1; each accepted beat written to slot wptr, beat index idx; toApp_axis_tvalid=0.
REQ-012 N_HDR, hdr_count==HDR_DEPTH, first beat (idx==0): N_DROP; fromNet_axis_tready=1, all beats discarded until tlast.
REQ-013 N_HDR, accepted beat idx==HDR_BEATS-1 without tlast: slot committed (wptr+1 mod HDR_DEPTH, hdr_count+1) same edge; idx=0; -> N_PAY.
REQ-014 N_HDR, accepted beat with tlast (incl. idx==HDR_BEATS-1): runt; no commit, idx=0, drop_cnt+1, stay N_HDR.
REQ-015 N_PAY: zero-latency pass-through; toApp_axis_* = fromNet_axis_* (valid, data, keep, user, last); fromNet_axis_tready=toApp_axis_tready; accepted tlast -> N_HDR.
REQ-016 N_DROP: accepted tlast -> drop_cnt+1, -> N_HDR; toApp_axis_tvalid=0.
REQ-017 App path FSM states A_IDLE, A_HDR, A_PAY; reset A_IDLE, beat index 0.
REQ-018 A_IDLE: fromApp_axis_tready=0, toNet_axis_tvalid=0; fromApp_axis_tvalid=1 and hdr_count>0 -> A_HDR next cycle.
REQ-019 A_HDR: toNet_axis_tvalid=1, tdata=slot rptr beat ridx, tkeep all ones, tuser=0, tlast=0; fromApp_axis_tready=0; ridx+1 per handshake; handshake on ridx==HDR_BEATS-1 -> ridx=0, A_PAY.
REQ-020 A_PAY: pass-through fromApp_axis_* -> toNet_axis_*, fromApp_axis_tready=toNet_axis_tready; accepted tlast frees slot (rptr+1 mod HDR_DEPTH, hdr_count-1), -> A_IDLE.
REQ-021 Commit and free same edge: hdr_count unchanged, both pointers advance.
REQ-022 Slot being read (rptr) never overwritten: commit only into slot wptr while hdr_count<HDR_DEPTH at packet start.
REQ-023 Headers paired to responses strictly FIFO; response i carries header of i-th committed request.
REQ-024 drop_cnt saturates at 2^32-1, never wraps.
REQ-025 Net and App paths independent; backpressure on one never stalls the other except via hdr_count.

Reset
REQ-026 apreset=1 at edge: both FSMs to reset state, wptr=rptr=idx=ridx=0, hdr_count=0, drop_cnt=0.
REQ-027 During and the cycle after reset: all tvalid=0, fromNet_axis_tready=0, fromApp_axis_tready=0.
REQ-028 Reset mid-packet: in-flight packets abandoned, no tlast emitted, store contents invalid; next fromNet beat treated as header beat 0.

Verification
REQ-029 HDR_BEATS=6, 10-beat request (tdata=beat number), tready=1 -> toApp gets beats 6..9, tlast on beat 9; hdr_count=1.
REQ-030 Then 3-beat app response A0..A2 -> toNet emits header beats 0..5 (keep 0xFF), then A0..A2, tlast on A2; hdr_count=0.
REQ-031 5 requests, no responses, HDR_DEPTH=4 -> first 4 committed, 5th fully accepted and dropped; drop_cnt=1, hdr_count=4, toApp sees 4 payloads.
REQ-032 4-beat request with tlast on beat 3 -> no toApp beat, drop_cnt=1, hdr_count=0; fromApp_axis_tvalid=1 keeps fromApp_axis_tready=0.
REQ-033 Backpressure: toApp_axis_tready low 9 of every 49 cycles, toNet_axis_tready low 10 of every 60, 100 random packets -> byte-exact outputs, header/response order preserved, no beat lost or duplicated.
REQ-034 apreset=1 for 1 cycle during toNet header beat 3 -> toNet_axis_tvalid=0 next cycle, hdr_count=0, drop_cnt=0; subsequent request/response pair correct.
